rf_write_arbiter: RTL

- Shares the single register-file write port between two sources:
  - the in-order pipeline writeback stage (data, destination and write enable already resolved);
  - a long-latency unit (multiply/divide or load-return) that uses a valid/ready handshake.
- Pipeline writes always win. Long-latency results wait in a small FIFO.
- A starvation counter raises a stall request so queued results eventually drain.
- Sits between the writeback stage and the regfile write port inside decode.

---
 rtl/rf_write_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/rf_write_arbiter.sv
// Shares the regfile write port between the in-order writeback stage and a
// long-latency result source. Pipeline writes win; long-latency results queue.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | queue empty, starve counter cleared
// S_WAIT  | queue holds a valid head, counting cycles without a pop
// S_STALL | head waited STARVE_LIMIT cycles, stall_req held until a pop
module rf_write_arbiter #(
   parameter int DEPTH        = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       wb_valid,
   input  logic [4:0]                 wb_rd,
   input  logic [31:0]                wb_data,
   input  logic                       lu_valid,
   input  logic [4:0]                 lu_rd,
   input  logic [31:0]                lu_data,
   output logic                       lu_ready,
   output logic                       rf_we,
   output logic [4:0]                 rf_waddr,
   output logic [31:0]                rf_wdata,
   output logic                       stall_req,
   output logic [$clog2(DEPTH):0]     pend_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WAIT  = 2'd1;
   localparam logic [1:0] S_STALL = 2'd2;

   logic [4:0]    q_rd   [DEPTH];
   logic [31:0]   q_data [DEPTH];
   logic [4:0]    n_rd   [DEPTH];
   logic [31:0]   n_data [DEPTH];
   logic [CW-1:0] cnt_q, cnt_d;
   logic [SW-1:0] starve_q, starve_d;
   logic [1:0]    state_q, state_d;
   logic          stall_d;

   logic wb_hit, lu_xfer, lu_live, pop, bypass, enq;

   assign wb_hit   = wb_valid && (wb_rd != 5'd0);
   assign lu_ready = (cnt_q < CW'(DEPTH));
   assign lu_xfer  = lu_valid && lu_ready;
   // Results for r0 or for a register the pipeline is writing now are stale.
   assign lu_live  = lu_xfer && (lu_rd != 5'd0) && !(wb_hit && (lu_rd == wb_rd));
   assign pop      = !wb_hit && (cnt_q != '0);
   assign bypass   = !wb_hit && (cnt_q == '0) && lu_live;
   assign enq      = lu_live && !bypass;
   assign pend_cnt = cnt_q;

   // The queue is kept compacted: squashed entries and the popped head are
   // removed in one step, so slot 0 is always a valid head when cnt_q != 0.
   always_comb begin
      logic [CW-1:0] k;
      n_rd   = q_rd;
      n_data = q_data;
      k      = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if ((CW'(i) < cnt_q) && !(pop && (i == 0)) &&
             !(wb_hit && (q_rd[i] == wb_rd))) begin
            n_rd[k[AW-1:0]]   = q_rd[i];
            n_data[k[AW-1:0]] = q_data[i];
            k = k + CW'(1);
         end
      end
      if (enq) begin
         n_rd[k[AW-1:0]]   = lu_rd;
         n_data[k[AW-1:0]] = lu_data;
         k = k + CW'(1);
      end
      cnt_d = k;
   end

   always_comb begin
      state_d  = state_q;
      starve_d = starve_q;
      stall_d  = stall_req;
      if (cnt_d == '0) begin
         state_d  = S_IDLE;
         starve_d = '0;
         stall_d  = 1'b0;
      end else if (pop) begin
         state_d  = S_WAIT;
         starve_d = '0;
         stall_d  = 1'b0;
      end else if (state_q == S_STALL) begin
         stall_d = 1'b1;
      end else if (cnt_q != '0) begin
         if (starve_q == SW'(STARVE_LIMIT)) begin
            state_d = S_STALL;
            stall_d = 1'b1;
         end else begin
            state_d  = S_WAIT;
            starve_d = starve_q + SW'(1);
         end
      end else begin
         state_d  = S_WAIT;
         starve_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      q_rd   <= n_rd;
      q_data <= n_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         starve_q  <= '0;
         state_q   <= S_IDLE;
         stall_req <= 1'b0;
         rf_we     <= 1'b0;
         rf_waddr  <= 5'd0;
         rf_wdata  <= 32'd0;
      end else begin
         cnt_q     <= cnt_d;
         starve_q  <= starve_d;
         state_q   <= state_d;
         stall_req <= stall_d;
         rf_we     <= wb_hit || pop || bypass;
         if (wb_hit) begin
            rf_waddr <= wb_rd;
            rf_wdata <= wb_data;
         end else if (pop) begin
            rf_waddr <= q_rd[0];
            rf_wdata <= q_data[0];
         end else if (bypass) begin
            rf_waddr <= lu_rd;
            rf_wdata <= lu_data;
         end
      end
   end

endmodule
